vga_frame_capture: RTL and testbench

- Sink-side counterpart of the VGA output stage: samples h_sync, v_sync, blank_n and rgb on each pixel strobe and rebuilds one armed frame into a write-only frame-memory port.
- Lets the RSA ASIP system compare encrypted and decrypted images in hardware, with no file dump needed.
- Sits in the clk domain beside the VGA controller; the memory port drives a single-port RAM.

---
 rtl/vga_frame_capture.sv | 169 ++++++++++++++++
 tb/tb_vga_frame_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: rebuilds one armed VGA frame from the sampled sync/blank/rgb
// stream and writes its active pixels in raster order to a single-port frame memory.
module vga_frame_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic              blank_n,
    input  logic [7:0]        rgb,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int unsigned NPIX   = H_ACTIVE * V_ACTIVE;
    localparam int unsigned PIX_W  = ADDR_W + 1;
    // One spare code above H_ACTIVE so a saturated over-long line never reads as H_ACTIVE
    localparam int unsigned COL_W  = $clog2(H_ACTIVE + 2);
    localparam int unsigned LINE_W = $clog2(V_ACTIVE + 2);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(NPIX);
    localparam logic [COL_W-1:0] H_LEN    = COL_W'(H_ACTIVE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                hs_q, hs_d;
    logic                vs_q, vs_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic [COL_W-1:0]    col_cnt_q, col_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;

    logic vs_rise, vs_fall, hs_fall, pix_wr, pix_last;

    assign vs_rise  = pix_en & v_sync & ~vs_q;
    assign vs_fall  = pix_en & ~v_sync & vs_q;
    assign hs_fall  = pix_en & ~h_sync & hs_q;
    assign pix_wr   = pix_en & blank_n & (pix_cnt_q != PIX_FULL);
    assign pix_last = pix_wr & (pix_cnt_q == PIX_LAST);

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            col_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            col_cnt_q  <= col_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Next-state: capture sequencing, pixel writes and line-length checking
    always_comb begin
        state_d    = state_q;
        hs_d       = pix_en ? h_sync : hs_q;
        vs_d       = pix_en ? v_sync : vs_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        col_cnt_d  = col_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_WAIT_VS;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    col_cnt_d  = '0;
                end
            end
            S_WAIT_VS: begin
                if (vs_rise) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (vs_fall) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (pix_wr) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = pix_cnt_q[ADDR_W-1:0];
                        wr_data_d = rgb;
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        if (col_cnt_q != '1) begin
                            col_cnt_d = col_cnt_q + 1'b1;
                        end
                    end
                    // Completion takes priority: the final line is never length-checked
                    if (pix_last) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (hs_fall && (col_cnt_q != '0)) begin
                        if (col_cnt_q != H_LEN) begin
                            err_d = 1'b1;
                        end
                        line_cnt_d = line_cnt_q + 1'b1;
                        col_cnt_d  = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = err_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: drives a small reference VGA raster (8x4 active) with
// random pixel data and checks frame-memory writes against a stream-level model.
module tb_vga_frame_capture;

    localparam int H         = 8;
    localparam int V         = 4;
    localparam int AW        = 5;
    localparam int NPIX      = H * V;
    localparam int LINE_LEN  = 14;   // 8 active + HFP 2 + HS 2 + HBP 2
    localparam int N_LINES   = 7;    // VFP, VS, VBP, then 4 active lines
    localparam int FIRST_ACT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_en, h_sync, v_sync, blank_n, start;
    logic [7:0]    rgb;
    logic          busy, done, frame_err, wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    int tests = 0;
    int fails = 0;

    // Reference model: a frame is armed by start, begins at the end of the next
    // vsync pulse, and its active pixels land at consecutive addresses.
    bit            m_busy, m_armed, m_capt, m_err, m_prev_vs;
    int            m_pushed;
    logic [AW-1:0] q_addr[$];
    logic [7:0]    q_data[$];
    int            done_cnt, wr_cnt;
    bit            prev_act;
    bit            start_req;

    vga_frame_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en),
        .h_sync   (h_sync),
        .v_sync   (v_sync),
        .blank_n  (blank_n),
        .rgb      (rgb),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .frame_err(frame_err),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every write must follow an active strobe by one clock and match the model
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (done === 1'b1) done_cnt++;
            if (wr_en === 1'b1) begin
                wr_cnt++;
                check("wr_latency", {31'd0, prev_act}, 32'd1);
                if (q_addr.size() == 0) begin
                    check("wr_spurious", q_addr.size(), 32'd1);
                end else begin
                    check("wr_addr", wr_addr, q_addr.pop_front());
                    check("wr_data", wr_data, q_data.pop_front());
                end
            end
        end
        prev_act = (pix_en === 1'b1) && (blank_n === 1'b1);
    end

    task automatic model_sample(input logic vs, input logic bl, input logic [7:0] d);
        if (m_capt && !vs && m_prev_vs) begin
            m_capt = 1'b0;
            m_err  = 1'b1;
            m_busy = 1'b0;
        end else if (m_armed && vs && !m_prev_vs) begin
            m_armed  = 1'b0;
            m_capt   = 1'b1;
            m_pushed = 0;
        end else if (m_capt && bl) begin
            q_addr.push_back(AW'(m_pushed));
            q_data.push_back(d);
            m_pushed++;
            if (m_pushed == NPIX) begin
                m_capt = 1'b0;
                m_busy = 1'b0;
            end
        end
        m_prev_vs = vs;
    endtask

    // One pixel period: three idle clocks (start may pulse in the first), then the strobe
    task automatic drive_pixel(input logic hs, input logic vs, input logic bl, input logic [7:0] d);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            pix_en = 1'b0;
            start  = 1'b0;
            if (i == 0 && start_req) begin
                start     = 1'b1;
                start_req = 1'b0;
                if (!m_busy) begin
                    m_busy  = 1'b1;
                    m_armed = 1'b1;
                    m_err   = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        start   = 1'b0;
        pix_en  = 1'b1;
        h_sync  = hs;
        v_sync  = vs;
        blank_n = bl;
        rgb     = d;
        model_sample(vs, bl, d);
    endtask

    task automatic apply_reset_mid();
        @(posedge clk); #1;
        pix_en = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", busy, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 32'd0);
        check("rst_wr_en", wr_en, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_err", frame_err, 32'd0);
        m_busy = 1'b0; m_armed = 1'b0; m_capt = 1'b0; m_err = 1'b0; m_prev_vs = 1'b1;
        q_addr.delete();
        q_data.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One frame; the indices count active pixels driven so far (-1 disables)
    task automatic drive_frame(input int start_at, input int short_line, input int abort_at, input int reset_at);
        int         act;
        int         al;
        int         na;
        bit         vlow;
        bit         bl_nom;
        logic       hs;
        logic [7:0] d;
        act = 0;
        for (int l = 0; l < N_LINES; l++) begin
            al   = l - FIRST_ACT;
            na   = (l >= FIRST_ACT) ? ((al == short_line) ? H - 1 : H) : 0;
            vlow = (l == 1);
            if (l >= FIRST_ACT && al == short_line && m_capt) m_err = 1'b1;
            for (int p = 0; p < LINE_LEN; p++) begin
                bl_nom = (p < na);
                hs     = !(p == 10 || p == 11);
                d      = 8'hFF;
                if (bl_nom && !vlow) begin
                    if (act == start_at) start_req = 1'b1;
                    if (act == abort_at) begin
                        vlow     = 1'b1;
                        abort_at = -1;
                    end
                    if (act == reset_at) apply_reset_mid();
                end
                if (bl_nom && !vlow) begin
                    d = 8'($urandom);
                    act++;
                end
                drive_pixel(hs, !vlow, bl_nom && !vlow, d);
            end
        end
        @(posedge clk); #1;
        pix_en = 1'b0;
    endtask

    task automatic end_checks(input string tag, input int exp_writes, input int exp_done);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_writes"}, wr_cnt, exp_writes);
        check({tag, "_done"}, done_cnt, exp_done);
        check({tag, "_err"}, frame_err, {31'd0, m_err});
        check({tag, "_busy"}, busy, {31'd0, m_busy});
        check({tag, "_left"}, q_addr.size(), 32'd0);
        done_cnt = 0;
        wr_cnt   = 0;
    endtask

    initial begin
        rst = 1'b0; pix_en = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
        blank_n = 1'b0; rgb = '0; start = 1'b0; start_req = 1'b0;
        m_busy = 1'b0; m_armed = 1'b0; m_capt = 1'b0; m_err = 1'b0;
        m_prev_vs = 1'b1; m_pushed = 0; done_cnt = 0; wr_cnt = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_val_busy", busy, 32'd0);
        check("rst_val_done", done, 32'd0);
        check("rst_val_err", frame_err, 32'd0);
        check("rst_val_wr_en", wr_en, 32'd0);
        check("rst_val_wr_addr", wr_addr, 32'd0);
        check("rst_val_wr_data", wr_data, 32'd0);
        rst = 1'b1;

        drive_frame(-1, -1, -1, -1);
        end_checks("idle", 0, 0);

        for (int k = 0; k < 2; k++) begin
            drive_frame(int'($urandom_range(0, NPIX - 1)), -1, -1, -1);
            drive_frame(-1, -1, -1, -1);
            end_checks("clean", NPIX, 1);
        end

        drive_frame(int'($urandom_range(0, NPIX - 1)), -1, -1, -1);
        drive_frame(-1, 2, -1, -1);
        check("short_err_mid", frame_err, 32'd1);
        check("short_busy_mid", busy, 32'd1);
        drive_frame(-1, -1, -1, -1);
        end_checks("short", NPIX - 1, 1);

        drive_frame(int'($urandom_range(0, NPIX - 1)), -1, -1, -1);
        check("restart_err_clr", frame_err, 32'd0);
        check("restart_busy", busy, 32'd1);
        drive_frame(int'($urandom_range(0, NPIX - 2)), -1, -1, -1);
        end_checks("restart", NPIX, 1);

        drive_frame(int'($urandom_range(0, NPIX - 1)), -1, -1, -1);
        drive_frame(-1, -1, 20, -1);
        end_checks("abort", 20, 1);
        check("abort_err", frame_err, 32'd1);

        drive_frame(int'($urandom_range(0, NPIX - 1)), -1, -1, -1);
        drive_frame(-1, -1, -1, 10);
        end_checks("reset", 10, 0);

        drive_frame(int'($urandom_range(0, NPIX - 1)), -1, -1, -1);
        drive_frame(-1, -1, -1, -1);
        end_checks("after_rst", NPIX, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        tests++;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
